piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the 1-bit serial shift path.
//  Accepts a WIDTH-bit word via valid/ready, then drives it out 1 bit/clk with framing.
//  Its sout feeds a serial-in shift chain.
//  Back-to-back words stream with no idle bit between frames.
// PARAMETERS
//  WIDTH      4   bits per word / frame length in clocks (>=2)
//  MSB_FIRST  0   0: bit0 transmitted first; 1: bit WIDTH-1 first
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  din         in   WIDTH  parallel word to transmit
//  din_valid   in   1      din holds a word to send
//  din_ready   out  1      block accepts din this cycle
//  sout        out  1      serial data bit
//  sout_valid  out  1      sout carries a frame bit this cycle
//  sof         out  1      high on first bit of each frame
//  busy        out  1      frame in progress (== sout_valid)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk release):
//    - state=IDLE, shreg=0, cnt=0.
//    - Outputs: sout=0, sout_valid=0, sof=0, busy=0, din_ready=1.
//  - FSM states: IDLE, SHIFT.
//  - Accept = din_valid & din_ready, sampled at posedge clk.
//  - din_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1).
//    - Combinational from regs only; no din_valid->din_ready path.
//  - IDLE:
//    - accept -> shreg<=din, cnt<=0, state<=SHIFT.
//    - no accept -> hold.
//  - SHIFT, cnt<WIDTH-1: shreg shifts toward output end by 1, zero fill; cnt<=cnt+1.
//  - SHIFT, cnt==WIDTH-1 (last bit on sout):
//    - accept -> reload shreg<=din, cnt<=0, stay SHIFT (gapless).
//    - no accept -> state<=IDLE, shreg<=0, cnt<=0.
//  - Output decode:
//    - sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0], when SHIFT; 0 in IDLE.
//    - sout_valid = busy = (state==SHIFT).
//    - sof = (state==SHIFT & cnt==0).
//  - Latency: first bit on sout the cycle after accept; frame is exactly WIDTH cycles.
//  - din_valid while din_ready=0 is ignored; the upstream must hold din until accept.
//    - The word in flight is never corrupted.
//  - Reset mid-frame aborts immediately: sout_valid drops asynchronously, the partial frame is lost.
//  - Counter width = clog2(WIDTH); it never exceeds WIDTH-1.
// STRUCTURE
//  - Shared package/header holds:
//    - state encodings IDLE=1'b0, SHIFT=1'b1;
//    - a clog2 function for counter width.
//  - One sub-module is natural: piso_bit_counter.
//    - Modulo-WIDTH up-counter with clear, enable and a last flag.
//  - Shift register and FSM stay in the top.
// TESTING (WIDTH=4 unless noted)
//  1. Reset, then idle -> sout=0, sout_valid=0, sof=0, din_ready=1 for 10 clk.
//  2. Single word, LSB first:
//     - Stimulus: din=4'b1011 accepted at edge E.
//     - Response: sout=1,1,0,1 on cycles E+1..E+4; sof only at E+1.
//     - Response: din_ready=0 at E+1..E+3, =1 at E+4; IDLE after E+4.
//  3. Back-to-back:
//     - Stimulus: 4'hA then 4'h5, din_valid held high.
//     - Response: 8 contiguous valid bits 0,1,0,1,1,0,1,0; sof at bit 1 and bit 5.
//  4. Held while busy:
//     - Stimulus: 4'h3 accepted; din changed to 4'hC at E+2 with din_valid=1.
//     - Response: frame sends 1,1,0,0 (4'h3 intact).
//     - Response: 4'hC accepted at the E+4 edge, sent E+5..E+8.
//  5. Reset mid-frame:
//     - Stimulus: rst_n=0 during bit 2 of 4'hF.
//     - Response: sout_valid=0 immediately; din_ready=1.
//     - Response: the next word after release transmits correctly.
//  6. MSB_FIRST=1, WIDTH=8:
//     - Stimulus: din=8'hC5.
//     - Response: sout=1,1,0,0,0,1,0,1 over 8 clk; sof on the first bit.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and a
// constant-evaluable clog2 used to size the bit counter.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Smallest r such that 2**r >= n; a 1-bit floor keeps WIDTH=2 legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit position counter with synchronous clear, enable and a
// last-bit flag; clear has priority over enable.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on valid/ready
// and drives it out one bit per clock, streaming gapless frames.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_en;
    logic             accept;
    logic [WIDTH-1:0] shreg_shifted;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Ready depends only on registered state so no valid->ready loop exists.
    assign din_ready = (state_q == IDLE) || cnt_last;
    assign accept    = din_valid && din_ready;

    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!cnt_last) begin
                    shreg_d = shreg_shifted;
                    cnt_en  = 1'b1;
                end else if (accept) begin
                    shreg_d = din;
                    cnt_clr = 1'b1;
                end else begin
                    shreg_d = '0;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign sof        = busy && (cnt == '0);
    assign sout       = busy && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a WIDTH=4 LSB-first instance driven
// from a vector table, plus a WIDTH=8 MSB-first instance and a reset abort.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;

    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sout_valid;
    logic       sof;
    logic       busy;

    logic [7:0] din8;
    logic       din8_valid;
    logic       din8_ready;
    logic       sout8;
    logic       sout8_valid;
    logic       sof8;
    logic       busy8;

    int n_checks;
    int n_pass;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sof        (sof),
        .busy       (busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din8),
        .din_valid  (din8_valid),
        .din_ready  (din8_ready),
        .sout       (sout8),
        .sout_valid (sout8_valid),
        .sof        (sof8),
        .busy       (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs applied during the cycle, outputs expected during it.
    typedef struct {
        logic [3:0] din;
        logic       valid;
        logic       sout;
        logic       sv;
        logic       sof;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] d, input logic v, input logic so,
                                input logic sv, input logic sf, input logic rd);
        vec_t r;
        r.din = d; r.valid = v; r.sout = so; r.sv = sv; r.sof = sf; r.rdy = rd;
        return r;
    endfunction

    // Called at a negedge: drive inputs, then compare the current outputs.
    task automatic apply(input vec_t v, input int idx);
        din       = v.din;
        din_valid = v.valid;
        #1;
        check($sformatf("v%0d_sout", idx),  8'(sout),       8'(v.sout));
        check($sformatf("v%0d_valid", idx), 8'(sout_valid), 8'(v.sv));
        check($sformatf("v%0d_sof", idx),   8'(sof),        8'(v.sof));
        check($sformatf("v%0d_ready", idx), 8'(din_ready),  8'(v.rdy));
        check($sformatf("v%0d_busy", idx),  8'(busy),       8'(v.sv));
    endtask

    initial begin
        logic [7:0] exp8;
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din8       = '0;
        din8_valid = 1'b0;

        // Single word 4'b1011, LSB first: 1,1,0,1
        vecs.push_back(mk(4'hB, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 0, 0, 1));
        // Back-to-back 4'hA then 4'h5: 0,1,0,1,1,0,1,0
        vecs.push_back(mk(4'hA, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h5, 1, 0, 1, 1, 0));
        vecs.push_back(mk(4'h5, 1, 1, 1, 0, 0));
        vecs.push_back(mk(4'h5, 1, 0, 1, 0, 0));
        vecs.push_back(mk(4'h5, 1, 1, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 0, 0, 1));
        // 4'h3 in flight while 4'hC is offered from E+2: 1,1,0,0 then 0,0,1,1
        vecs.push_back(mk(4'h3, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h3, 0, 1, 1, 1, 0));
        vecs.push_back(mk(4'hC, 1, 1, 1, 0, 0));
        vecs.push_back(mk(4'hC, 1, 0, 1, 0, 0));
        vecs.push_back(mk(4'hC, 1, 0, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 0, 0, 1));

        // Reset values while held in reset
        #7;
        check("rst_sout",  8'(sout),       8'd0);
        check("rst_valid", 8'(sout_valid), 8'd0);
        check("rst_sof",   8'(sof),        8'd0);
        check("rst_ready", 8'(din_ready),  8'd1);
        check("rst_busy",  8'(busy),       8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 10 clocks
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(mk(4'h0, 0, 0, 0, 0, 1), 1000 + i);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i], i);
        end

        // Reset during bit 2 of 4'hF aborts the frame at once
        @(negedge clk); apply(mk(4'hF, 1, 0, 0, 0, 1), 2000);
        @(negedge clk); apply(mk(4'h0, 0, 1, 1, 1, 0), 2001);
        @(negedge clk); apply(mk(4'h0, 0, 1, 1, 0, 0), 2002);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 8'(sout_valid), 8'd0);
        check("abort_ready", 8'(din_ready),  8'd1);
        check("abort_sout",  8'(sout),       8'd0);
        check("abort_busy",  8'(busy),       8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Next word 4'h6 after release: 0,1,1,0
        @(negedge clk); apply(mk(4'h6, 1, 0, 0, 0, 1), 2010);
        @(negedge clk); apply(mk(4'h0, 0, 0, 1, 1, 0), 2011);
        @(negedge clk); apply(mk(4'h0, 0, 1, 1, 0, 0), 2012);
        @(negedge clk); apply(mk(4'h0, 0, 1, 1, 0, 0), 2013);
        @(negedge clk); apply(mk(4'h0, 0, 0, 1, 0, 1), 2014);
        @(negedge clk); apply(mk(4'h0, 0, 0, 0, 0, 1), 2015);

        // WIDTH=8 MSB-first: 8'hC5 -> 1,1,0,0,0,1,0,1
        @(negedge clk);
        check("w8_idle_ready", 8'(din8_ready),  8'd1);
        check("w8_idle_valid", 8'(sout8_valid), 8'd0);
        din8       = 8'hC5;
        din8_valid = 1'b1;
        exp8       = 8'b1100_0101;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din8_valid = 1'b0;
            din8       = 8'h00;
            #1;
            check($sformatf("w8_b%0d_sout", i),  8'(sout8),       8'(exp8[7-i]));
            check($sformatf("w8_b%0d_valid", i), 8'(sout8_valid), 8'd1);
            check($sformatf("w8_b%0d_sof", i),   8'(sof8),        8'(i == 0));
            check($sformatf("w8_b%0d_ready", i), 8'(din8_ready),  8'(i == 7));
        end
        @(negedge clk);
        #1;
        check("w8_end_valid", 8'(sout8_valid), 8'd0);
        check("w8_end_sout",  8'(sout8),       8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
